// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - load/store arbiter sequencing cache accesses and memory refills
module cache_ctrl #(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W        = 6
) (
  input  logic             clk,
  input  logic             rstn,
  // load request port
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic             ld_size,
  input  logic [TAG_W-1:0] ld_tag,
  // store request port
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             st_size,
  // cache side
  output logic [31:0]      cache_addr,
  output logic [31:0]      cache_wdata,
  output logic             cache_memRead,
  output logic             cache_memWrite,
  output logic             cache_size,
  input  logic [31:0]      cache_lw_data,
  input  logic             cache_miss,
  // memory side
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  // load response
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_miss,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    CHECK   = 3'd2,
    MEM_REQ = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      cap_addr;
  logic             cap_size;
  logic             cap_is_ld;
  logic [TAG_W-1:0] cap_tag;

  logic load_prio;
  logic st_acc;
  logic ld_acc;

  // Refill data is narrowed to the requested access size, upper bits zeroed.
  function automatic logic [31:0] size_mask(input logic [31:0] d, input logic sz);
    return sz ? {24'b0, d[7:0]} : {16'b0, d[15:0]};
  endfunction

  // A waiting load overrides the default store priority once it has been passed over enough times.
  assign load_prio = ld_valid && (starve_cnt == CNT_MAX);

  // Readies are gated by rstn so nothing can be accepted while reset is held.
  assign st_ready = rstn && (state == IDLE) && !load_prio;
  assign ld_ready = rstn && (state == IDLE) && (load_prio || !st_valid);

  assign st_acc = st_valid && st_ready;
  assign ld_acc = ld_valid && ld_ready;

  assign busy = (state != IDLE);

  // Main sequencer: arbitration, capture, cache strobe, refill handshake and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      cap_addr       <= '0;
      cap_size       <= 1'b0;
      cap_is_ld      <= 1'b0;
      cap_tag        <= '0;
      cache_addr     <= '0;
      cache_wdata    <= '0;
      cache_memRead  <= 1'b0;
      cache_memWrite <= 1'b0;
      cache_size     <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_tag       <= '0;
      resp_miss      <= 1'b0;
    end else begin
      // Single-cycle strobes default low; each state raises its own.
      cache_memRead  <= 1'b0;
      cache_memWrite <= 1'b0;
      resp_valid     <= 1'b0;

      case (state)
        IDLE: begin
          if (st_acc) begin
            cap_addr       <= st_addr;
            cap_size       <= st_size;
            cap_is_ld      <= 1'b0;
            cache_addr     <= st_addr;
            cache_wdata    <= st_data;
            cache_size     <= st_size;
            cache_memWrite <= 1'b1;
            state          <= ACCESS;
            if (ld_valid && (starve_cnt != CNT_MAX)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (ld_acc) begin
            cap_addr      <= ld_addr;
            cap_size      <= ld_size;
            cap_is_ld     <= 1'b1;
            cap_tag       <= ld_tag;
            cache_addr    <= ld_addr;
            cache_size    <= ld_size;
            cache_memRead <= 1'b1;
            starve_cnt    <= '0;
            state         <= ACCESS;
          end
        end

        ACCESS: begin
          // Stores complete here; the cache's miss indication is irrelevant for them.
          state <= cap_is_ld ? CHECK : IDLE;
        end

        CHECK: begin
          if (cache_miss) begin
            mem_req  <= 1'b1;
            mem_addr <= cap_addr;
            state    <= MEM_REQ;
          end else begin
            resp_valid <= 1'b1;
            resp_data  <= cache_lw_data;
            resp_miss  <= 1'b0;
            resp_tag   <= cap_tag;
            state      <= RESP;
          end
        end

        MEM_REQ: begin
          // No timeout: the request stays up until memory answers.
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= size_mask(mem_rdata, cap_size);
            resp_miss  <= 1'b1;
            resp_tag   <= cap_tag;
            state      <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive store grants while a load waits.
REQ-002 Parameter: TAG_W, default 6, width of load ROB tag.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rstn  input  1  asynchronous active-low reset.
REQ-006 Ports, load port: ld_valid in 1; ld_ready out 1; ld_addr in 32; ld_size in 1 (1 = byte, 0 = halfword); ld_tag in TAG_W.
REQ-007 Ports, store port: st_valid in 1; st_ready out 1; st_addr in 32; st_data in 32; st_size in 1 (same encoding as ld_size).
REQ-008 Ports, cache side: cache_addr out 32; cache_wdata out 32; cache_memRead out 1; cache_memWrite out 1; cache_size out 1; cache_lw_data in 32; cache_miss in 1. The cache registers cache_lw_data/cache_miss on the edge that ends a cycle with cache_memRead high.
REQ-009 Ports, memory side: mem_req out 1; mem_addr out 32; mem_ack in 1; mem_rdata in 32.
REQ-010 Ports, response: resp_valid out 1; resp_data out 32; resp_tag out TAG_W; resp_miss out 1; busy out 1 (state != IDLE).

Function
REQ-011 FSM states: IDLE, ACCESS, CHECK, MEM_REQ, RESP.
REQ-012 Handshake: a request is accepted on a rising edge where valid && ready; the accepted addr/data/size/tag are captured into internal registers on that edge.
REQ-013 ld_ready and st_ready are low outside IDLE; at most one is accepted per cycle.
REQ-014 Arbitration in IDLE: store wins by default; load wins when starve_cnt == STARVE_LIMIT and ld_valid is high.
REQ-015 starve_cnt: 0 at reset; +1 on a store grant while ld_valid is high; saturates at STARVE_LIMIT; cleared on a load grant.
REQ-016 IDLE -> ACCESS on any accept.
REQ-017 ACCESS lasts one cycle: cache_addr, cache_wdata and cache_size take the captured values; cache_memWrite = 1 for a store, cache_memRead = 1 for a load.
REQ-018 cache_memRead and cache_memWrite are 0 in every state other than ACCESS; cache_addr, cache_wdata and cache_size hold their last values.
REQ-019 Store: ACCESS -> IDLE. cache_miss is ignored and no response is generated, so a store accepted at cycle T lets st_ready return at T+2.
REQ-020 Load: ACCESS -> CHECK. In CHECK, cache_miss = 0 -> RESP, latching resp_data = cache_lw_data and resp_miss = 0.
REQ-021 In CHECK, cache_miss = 1 -> MEM_REQ.
REQ-022 MEM_REQ: mem_req = 1 and mem_addr = captured address, both held stable until mem_ack is sampled high; there is no timeout.
REQ-023 On a mem_ack edge, go to RESP and latch resp_miss = 1 and resp_data = mem_rdata masked: byte -> {24'b0, [7:0]}; halfword -> {16'b0, [15:0]}. mem_req deasserts in the cycle after ack.
REQ-024 RESP lasts one cycle: resp_valid = 1, resp_tag = captured ld_tag; then go to IDLE. Responses cannot be back-pressured.
REQ-025 Load-hit latency: accept at T -> resp_valid at T+3, ld_ready available again at T+4.
REQ-026 resp_data, resp_tag and resp_miss hold their values after resp_valid falls.
REQ-027 mem_ack outside MEM_REQ is ignored; the cache read inputs are ignored outside CHECK.

Reset
REQ-028 rstn low forces state to IDLE and clears starve_cnt, captured registers and every output to 0.
REQ-029 Reset asserted mid-operation (any state) drops the in-flight request with no response; a pending mem_req is withdrawn immediately.
REQ-030 The first accept after rstn rises takes place no earlier than the first rising edge with rstn high.

Verification
REQ-031 Scenario, load hit: cache preloaded (store 0x00AB at 0x1000 byte), then load 0x1000 byte, tag 5 -> resp_valid 3 cycles after accept, resp_data 0x000000AB, resp_tag 5, resp_miss 0.
REQ-032 Scenario, load miss: load 0x2000 halfword with cache_miss = 1; mem_ack 4 cycles after mem_req, mem_rdata 0xDEADBEEF -> mem_addr 0x2000 held throughout, resp_data 0x0000BEEF, resp_miss 1.
REQ-033 Scenario, store timing: st_valid with addr 0x40, data 0x1234, halfword -> cache_memWrite for exactly one cycle with cache_addr 0x40 and cache_wdata 0x1234, no resp_valid, st_ready high again at T+2.
REQ-034 Scenario, starvation: ld_valid and st_valid held continuously, STARVE_LIMIT = 4 -> exactly 4 store grants, then 1 load grant, then starve_cnt back to 0.
REQ-035 Scenario, reset mid-miss: rstn pulsed low while in MEM_REQ -> mem_req 0 asynchronously, no resp_valid, busy 0, ld_ready high on the first edge after release.
REQ-036 Scenario, spurious ack: mem_ack pulsed while in IDLE -> no state change and no response.
